// File: rtl/led_pio_out.sv
// Avalon-MM LED output PIO: data register with set/clear aliases and a
// per-bit blink engine clocked by a programmable down-counting prescaler.
module led_pio_out #(
  parameter int                 WIDTH          = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE    = '0,
  parameter int                 PRESCALE_WIDTH = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0]          r_data;
  logic [WIDTH-1:0]          r_blink_en;
  logic [PRESCALE_WIDTH-1:0] r_period;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      r_phase;
  logic [31:0]               r_readdata;

  logic                      w_wr;
  logic [31:0]               w_rd;

  assign w_wr = chipselect & ~write_n;

  // Host-visible registers; outset/outclear are write-only aliases of data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE;
      r_blink_en <= '0;
      r_period   <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data     <= writedata[WIDTH-1:0];
        ADDR_BLINK_EN: r_blink_en <= writedata[WIDTH-1:0];
        ADDR_PERIOD:   r_period   <= writedata[PRESCALE_WIDTH-1:0];
        ADDR_OUTSET:   r_data     <= r_data | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: r_data     <= r_data & ~writedata[WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  // A period write restarts the count from the new value with phase cleared,
  // taking priority over the normal reload/decrement step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wr && address == ADDR_PERIOD) begin
      r_cnt   <= writedata[PRESCALE_WIDTH-1:0];
      r_phase <= 1'b0;
    end else if (r_period == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt   <= r_period;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:     w_rd[WIDTH-1:0]          = r_data;
      ADDR_BLINK_EN: w_rd[WIDTH-1:0]          = r_blink_en;
      ADDR_PERIOD:   w_rd[PRESCALE_WIDTH-1:0] = r_period;
      ADDR_STATUS:   w_rd[0]                  = r_phase;
      default:       w_rd                     = '0;
    endcase
  end

  // Read path is address-driven every cycle, regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd;
  end

  assign readdata = r_readdata;
  assign out_port = r_data & ~(r_blink_en & {WIDTH{r_phase}});

endmodule

// File: tb/tb_led_pio_out.sv
// Directed bench for led_pio_out: reset, set/clear, blink timing, period
// rewrite, bus qualification and asynchronous reset.
module tb_led_pio_out;

  localparam int          WIDTH = 8;
  localparam logic [7:0]  RV    = 8'hA5;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  led_pio_out #(
    .WIDTH          (WIDTH),
    .RESET_VALUE    (RV),
    .PRESCALE_WIDTH (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  logic [31:0] rd;
  logic [31:0] exp_rd;
  logic [7:0]  exp_out;

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset
    repeat (3) @(negedge clk);
    check("reset_out_port", {24'd0, out_port}, {24'd0, RV});
    check("reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], rd);
      exp_rd = (a == 0) ? {24'd0, RV} : 32'd0;
      check($sformatf("reset_read_a%0d", a), rd, exp_rd);
    end

    // Set / clear aliases
    bus_write(3'd0, 32'h0000_000F);
    check("data_write", {24'd0, out_port}, 32'h0F);
    bus_write(3'd4, 32'hFFFF_FFF0);
    check("outset", {24'd0, out_port}, 32'hFF);
    bus_write(3'd5, 32'h0000_0003);
    check("outclear", {24'd0, out_port}, 32'hFC);
    bus_read(3'd0, rd);
    check("read_data_fc", rd, 32'h0000_00FC);
    bus_read(3'd4, rd);
    check("read_outset", rd, 32'd0);
    bus_read(3'd5, rd);
    check("read_outclear", rd, 32'd0);

    // Blink with period 3: phase toggles on the 4th edge after the write
    bus_write(3'd0, 32'hFF);
    bus_write(3'd1, 32'h01);
    bus_write(3'd2, 32'd3);
    address = 3'd3;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_out = (((k / 4) % 2) == 1) ? 8'hFE : 8'hFF;
      check($sformatf("blink_out_k%0d", k), {24'd0, out_port}, {24'd0, exp_out});
      check($sformatf("blink_status_k%0d", k), readdata, 32'(((k - 1) / 4) % 2));
    end

    // Period rewrite to 0 while phase = 1 (edges 13 and 14 stay in phase 1)
    bus_write(3'd2, 32'd0);
    check("period0_out", {24'd0, out_port}, 32'hFF);
    address = 3'd3;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("period0_hold_out", {24'd0, out_port}, 32'hFF);
      if (k > 0) check("period0_hold_status", readdata, 32'd0);
    end

    // Bus qualification: no chipselect, and writes to status/reserved
    @(negedge clk);
    address    = 3'd0;
    writedata  = 32'h0;
    write_n    = 1'b0;
    chipselect = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    check("no_cs_out", {24'd0, out_port}, 32'hFF);
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'h0000_0000);
    bus_read(3'd0, rd);
    check("qual_data", rd, 32'hFF);
    bus_read(3'd1, rd);
    check("qual_blink_en", rd, 32'h01);
    bus_read(3'd2, rd);
    check("qual_period", rd, 32'd0);
    bus_read(3'd3, rd);
    check("qual_status", rd, 32'd0);
    bus_read(3'd6, rd);
    check("qual_read6", rd, 32'd0);

    // Async reset mid-blink
    bus_write(3'd2, 32'd3);
    repeat (5) @(negedge clk);
    check("pre_reset_blink", {24'd0, out_port}, 32'hFE);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out", {24'd0, out_port}, {24'd0, RV});
    check("async_reset_rd", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_reset_out", {24'd0, out_port}, {24'd0, RV});
    end
    bus_read(3'd2, rd);
    check("post_reset_period", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
